// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and zeroed bubble control.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with registered ready_o.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 111
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stateT;

  stateT             state_q, state_d;
  logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d;
  logic [DATA_W-1:0] mainData_q, mainData_d;
`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;
  logic [DATA_W-1:0] skidData_q, skidData_d;
`endif

  logic acc;
  logic fire;

  assign valid_o = (state_q != EMPTY);
`ifdef PIPE_STAGE_SKID_EN
  assign ready_o = (state_q != TWO);
`else
  assign ready_o = !valid_o || ready_i;
`endif
  assign acc     = valid_i && ready_o;
  assign fire    = valid_o && ready_i;

  // Control is masked whenever the stage is empty, so a bubble never carries stale write enables.
  assign ctrl_o  = valid_o ? mainCtrl_q : '0;
  assign data_o  = mainData_q;
  assign count_o = state_q;

  always_comb begin
    state_d    = state_q;
    mainCtrl_d = mainCtrl_q;
    mainData_d = mainData_q;
`ifdef PIPE_STAGE_SKID_EN
    skidCtrl_d = skidCtrl_q;
    skidData_d = skidData_q;
`endif
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            mainCtrl_d = ctrl_i;
            mainData_d = data_i;
            state_d    = ONE;
          end
        end
        ONE: begin
          if (acc && fire) begin
            mainCtrl_d = ctrl_i;
            mainData_d = data_i;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (acc) begin
            skidCtrl_d = ctrl_i;
            skidData_d = data_i;
            state_d    = TWO;
          end
`endif
          else if (fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
`ifdef PIPE_STAGE_SKID_EN
          if (fire) begin
            mainCtrl_d = skidCtrl_q;
            mainData_d = skidData_q;
            state_d    = ONE;
          end
`else
          state_d = EMPTY;
`endif
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= EMPTY;
      mainCtrl_q <= '0;
      mainData_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skidCtrl_q <= '0;
      skidData_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mainCtrl_q <= mainCtrl_d;
      mainData_q <= mainData_d;
`ifdef PIPE_STAGE_SKID_EN
      skidCtrl_q <= skidCtrl_d;
      skidData_q <= skidData_d;
`endif
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register: the generic successor to the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB latches in the pipelined CPU. It adds the following on top of a plain latch:
- a valid/ready handshake, so stages can stall;
- a synchronous flush that inserts a bubble;
- an optional two-entry skid buffer that registers `ready_o` and removes the combinational ready path.

Control fields are separated from the datapath payload so that a bubble always carries zeroed control. A bubble therefore never writes memory or the register file.

## Interface
Parameters:
- `CTRL_W`, default 8: width of the control bundle (WB/M/EX bits); forced to 0 on bubble.
- `DATA_W`, default 111: width of the payload bundle (operands, immediate, register indices).

Ports:
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: asynchronous, active-low reset.
- `valid_i`, input, 1: upstream has an entry.
- `ready_o`, output, 1: stage can accept an entry.
- `ctrl_i`, input, `CTRL_W`: upstream control bundle.
- `data_i`, input, `DATA_W`: upstream payload.
- `flush_i`, input, 1: synchronous flush (branch taken or hazard).
- `valid_o`, output, 1: output entry is valid.
- `ready_i`, input, 1: downstream accepts the output entry.
- `ctrl_o`, output, `CTRL_W`: output control; 0 whenever `valid_o` = 0.
- `data_o`, output, `DATA_W`: output payload.
- `count_o`, output, 2: number of entries held (0..2).

## Operation
- Accept: `acc` = `valid_i` & `ready_o`. Fire: `fire` = `valid_o` & `ready_i`.
- Upstream holds `valid_i`, `ctrl_i` and `data_i` stable until accepted, unless flushed.
- Storage:
  - Main register drives `ctrl_o`, `data_o` and `valid_o`.
  - Skid register holds an overflow entry (skid build only).
- State machine (skid build), with state = `count_o`:
  - EMPTY(0):
    - `acc` -> main <= input; go to ONE.
  - ONE(1):
    - `acc` & `fire` -> main <= input; stay in ONE.
    - `acc` & !`fire` -> skid <= input; go to TWO.
    - !`acc` & `fire` -> go to EMPTY.
    - Otherwise hold.
  - TWO(2):
    - `ready_o` = 0, so no accept is possible.
    - `fire` -> main <= skid; go to ONE.
    - Otherwise hold.
- `ready_o` = (state != TWO). It is decoded from registered state only.
- Flush has highest priority:
  - On a rising edge with `flush_i` = 1, state goes to EMPTY and both entries are invalidated.
  - `ctrl_o` goes to 0.
  - Any simultaneous `acc` or `fire` is discarded; the entry is dropped and is not counted as transferred.
  - `data_o` keeps its last value (a don't-care while invalid).
- When `valid_o` = 0, `ctrl_o` must read 0 in every cycle, not only after a flush.
- Ordering is strict FIFO. Entries are never duplicated or reordered.

## Timing
- Reset (`rst_i` = 0, asynchronous): `valid_o` = 0, `ctrl_o` = 0, `data_o` = 0, `count_o` = 0, skid cleared, `ready_o` = 1.
- Reset asserted mid-operation clears all state immediately. The first accept is possible on the first rising edge after `rst_i` deasserts.
- Latency: an entry accepted at edge N is visible on `valid_o`/`data_o` after edge N. There is no combinational path from input to output.
- Throughput: one entry per cycle with `ready_i` held at 1. `count_o` stays ≤ 1 in that case.
- Skid build: `ready_o` drops one cycle after the entry that fills the skid is accepted. It rises after the edge where TWO fires.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two-entry skid buffer. `ready_o` is registered and `count_o` ranges over 0..2.
- `PIPE_STAGE_SKID_EN` undefined: single main register, no skid storage.
  - `ready_o` = !`valid_o` | `ready_i`, combinational from `ready_i`.
  - `count_o` ranges over 0..1; state TWO is unreachable.
  - Flush and reset behaviour are identical to the skid build.

## Test plan
- Reset: drive `rst_i` = 0 mid-stream with random inputs -> `valid_o` = 0, `ctrl_o` = 0x00, `data_o` = 0, `count_o` = 0, `ready_o` = 1 immediately, without waiting for a clock edge.
- Streaming: hold `ready_i` = 1 and push (`ctrl` 0x11, `data` 0xDEADBEEF) then (0x22, 0x0BADF00D) on consecutive edges -> each appears on the outputs one cycle later, `count_o` stays at 1, and there are no gaps.
- Backpressure, skid build, `CTRL_W` = 8, `DATA_W` = 32: with `ready_i` = 0, push A (0xA1, 0x1) then B (0xB2, 0x2).
  - Expect `count_o` = 2 and `ready_o` = 0, with `data_o` holding 0x1.
  - Raise `ready_i` -> A fires, then B fires on the next edge.
  - `ready_o` returns to 1 after A fires, and `count_o` reaches 0 after B.
- Flush: in TWO with `valid_i` = 1 and `ready_i` = 1, assert `flush_i` for one cycle.
  - Expect `valid_o` = 0, `ctrl_o` = 0x00, `count_o` = 0 and `data_o` = 0x1 retained.
  - The offered input must never appear on the outputs.
- Non-skid build (`PIPE_STAGE_SKID_EN` undefined): with `valid_o` = 1, toggle `ready_i` 0 -> 1 within one cycle -> `ready_o` follows 0 -> 1 combinationally in that same cycle, and an entry accepted there replaces main at the next edge.
